// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load memory-access stage: word read, byte/half extract, fault pulse
//
// Accepts one decoded load at a time, issues a word-aligned data-memory read,
// waits for the acknowledge, extracts and extends the addressed field and
// presents a single-cycle write-back (or fault) pulse.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake; accepted in IDLE when req_valid=1
//   load_type           one-hot: bit0 lw, bit1 lh, bit2 lhu, bit3 lb, bit4 lbu
//   addr, rd_in         effective byte address, destination register tag
//   mem_req, mem_addr   word-aligned read request, held until mem_ack
//   mem_rdata, mem_ack  read data and completion
//   wb_valid            one-cycle result/fault pulse
//   wb_data, wb_rd      extended result (0 on fault), destination tag
//   wb_err, err_code    fault flag; 01 misaligned, 10 illegal type, 11 timeout
module load_align_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      load_type,
  input  logic [XLEN-1:0] addr,
  input  logic [4:0]      rd_in,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_err,
  output logic [1:0]      err_code
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [4:0]        r_type;
  logic [1:0]        r_addr_lo;
  logic [4:0]        r_rd;
  logic [CW-1:0]     r_cnt;

  logic              w_legal_type;
  logic              w_misalign;
  logic              w_fault;
  logic              w_timeout;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;
  logic [XLEN-1:0]   w_ext;

  // Exactly one bit set: x & (x-1) clears the lowest set bit.
  assign w_legal_type = (load_type != 5'd0) && ((load_type & (load_type - 5'd1)) == 5'd0);
  assign w_misalign   = (load_type[0] && (addr[1:0] != 2'b00)) ||
                        ((load_type[1] || load_type[2]) && addr[0]);
  assign w_fault      = !w_legal_type || w_misalign;

  // The ack takes priority over the timeout when both land on the same edge.
  assign w_timeout    = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1)) && !mem_ack;

  assign req_ready    = (r_state == S_IDLE);

  always_comb begin
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_addr_lo)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_ext = '0;
    if (r_type[0])      w_ext = mem_rdata;
    else if (r_type[1]) w_ext = {{(XLEN-16){w_half[15]}}, w_half};
    else if (r_type[2]) w_ext = {{(XLEN-16){1'b0}}, w_half};
    else if (r_type[3]) w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
    else if (r_type[4]) w_ext = {{(XLEN-8){1'b0}}, w_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = w_fault ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_ack || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type    <= '0;
      r_addr_lo <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_err    <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_type    <= load_type;
            r_addr_lo <= addr[1:0];
            r_rd      <= rd_in;
            r_cnt     <= '0;
            if (w_fault) begin
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              err_code <= w_legal_type ? 2'b01 : 2'b10;
              wb_data  <= '0;
              wb_rd    <= rd_in;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {addr[XLEN-1:2], 2'b00};
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b0;
            err_code <= 2'b00;
            wb_data  <= w_ext;
            wb_rd    <= r_rd;
          end else if (w_timeout) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            err_code <= 2'b11;
            wb_data  <= '0;
            wb_rd    <= r_rd;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Memory-access stage directly downstream of the load-type decoder.
- Takes the decoder's one-hot load type, the effective address and the destination register. Issues a word-aligned data-memory read and waits for the acknowledge.
- Extracts and sign- or zero-extends the addressed byte, halfword or word.
- Presents a single-cycle write-back pulse, or a fault pulse for misaligned, illegal or timed-out accesses.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 16, maximum cycles to wait for mem_ack before faulting. 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  load request present
- req_ready  output  1  unit can accept a request
- load_type  input  5  one-hot: bit0 lw, bit1 lh, bit2 lhu, bit3 lb, bit4 lbu
- addr  input  XLEN  effective byte address
- rd_in  input  5  destination register tag
- mem_req  output  1  data-memory read request
- mem_addr  output  XLEN  word-aligned read address
- mem_rdata  input  XLEN  read data, valid when mem_ack=1
- mem_ack  input  1  read completion
- wb_valid  output  1  one-cycle result or fault pulse
- wb_data  output  XLEN  extended load result
- wb_rd  output  5  destination tag of the result
- wb_err  output  1  fault flag, qualified by wb_valid
- err_code  output  2  01 misaligned, 10 illegal type, 11 timeout, 00 none

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1.
  - mem_req=0, mem_addr=0.
  - wb_valid=0, wb_data=0, wb_rd=0, wb_err=0, err_code=00.
  - Timeout counter=0.
  - All outstanding work is abandoned. A mem_ack arriving after reset is ignored.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1. A request is accepted when req_valid=1 at the clock edge.
  - addr, load_type and rd_in are latched on acceptance.
  - Illegal type: load_type is zero or has more than one bit set. Go to RESP with wb_err=1, err_code=10. No mem_req is issued.
  - Misaligned: lw with addr[1:0]!=0, or lh/lhu with addr[0]=1. Go to RESP with err_code=01. No mem_req is issued.
  - Otherwise go to WAIT with mem_req=1, mem_addr={addr[XLEN-1:2],2'b00} and the counter cleared.
- WAIT:
  - req_ready=0.
  - mem_req and mem_addr are held stable until mem_ack=1 is sampled.
  - On mem_ack, mem_rdata is captured and extracted:
    - lw: full word.
    - lh/lhu: the halfword selected by addr[1]; lh sign-extends from bit15, lhu zero-extends.
    - lb/lbu: the byte selected by addr[1:0]; lb sign-extends from bit7, lbu zero-extends.
  - After capture: mem_req=0, go to RESP.
  - Each cycle without mem_ack increments the counter. With TIMEOUT>0 and counter==TIMEOUT-1 and no ack, go to RESP with err_code=11, mem_req=0, wb_data=0.
  - If mem_ack arrives in the same cycle the timeout would fire, the ack wins.
- RESP:
  - wb_valid=1 for exactly one cycle. wb_rd holds the latched tag.
  - wb_data holds the extended value. It is 0 on any fault.
  - Next state is IDLE. req_ready returns to 1 the following cycle.
- Outputs are registered. wb_data, wb_rd, wb_err and err_code hold their values after the pulse until the next RESP.
- Latency: accept at edge T, mem_req high from T+1. Ack sampled at edge N gives wb_valid during cycle N+1. Best case with an immediate ack is wb_valid at T+2. A fault on accept gives wb_valid at T+1.
- Throughput: one load in flight. No new request is accepted while in WAIT or RESP.
- mem_ack while in IDLE or RESP is ignored.

Test Plan:
- lb, addr=0x1003, mem_rdata=0x80FF_1234 with ack on the first mem_req cycle -> mem_addr=0x1000, wb_data=0xFFFF_FF80, wb_valid 2 cycles after accept, wb_err=0.
- lhu, addr=0x2002, mem_rdata=0xBEEF_0001, ack delayed 3 cycles -> mem_req held for 4 cycles with mem_addr=0x2000 stable, then wb_data=0x0000_BEEF. lh with the same data -> 0xFFFF_BEEF.
- lw, addr=0x3002 -> no mem_req, wb_valid the next cycle with wb_err=1, err_code=01, wb_data=0. load_type=5'b00011 -> err_code=10.
- TIMEOUT=16 and mem_ack never asserted -> after 16 WAIT cycles mem_req drops, wb_err=1, err_code=11. A second run with the ack on the final cycle -> normal result.
- rst_n pulsed low while in WAIT, then mem_ack asserted after release -> all outputs at reset values, no wb_valid, req_ready=1.
- Back-to-back: req_valid held high with two lw requests at rd 5 and rd 9 -> second accepted only after the first wb_valid. The two wb_rd pulses are 5 then 9, with req_ready low throughout WAIT and RESP.
